uart_cmd_decoder: RTL and testbench
===================================

# uart_cmd_decoder

Byte-stream command decoder between the UART receiver and the memory/IO write consumers (MDA video RAM, OPL2 register port). Parses framed packets from the 8-bit valid-strobed receive stream into single-cycle write strobes with a 20-bit address and 8-bit data. It replaces free-running address auto-increment with explicit address setting, block writes and IO writes. An inactivity timeout resynchronises the parser after a dropped byte.

## Interface

- TIMEOUT_CYCLES, 250000: consecutive cycles without a byte, mid-packet, before the packet is abandoned (10 ms at 25 MHz).
- ADDR_RESET, 20'hB0000: memory address pointer value after reset.

- iClk  in  1  system clock (25 MHz).
- iReset  in  1  reset, asynchronous, active-high.
- iData  in  8  received byte.
- iValid  in  1  one-cycle strobe, iData valid.
- oAddr  out  20  write address; memory address for oMemWr, {4'h0, port} for oIoWr.
- oData  out  8  write data.
- oMemWr  out  1  one-cycle memory write strobe.
- oIoWr  out  1  one-cycle IO write strobe.
- oBusy  out  1  high while a packet is in progress (state != IDLE).
- oErr  out  1  one-cycle strobe on timeout or unknown command byte.

## Operation

- Commands, first byte of each packet:
  - 0x01 SET_ADDR: 3 bytes a0, a1, a2 (little-endian). ptr <= {a2[3:0], a1, a0}; a2[7:4] ignored.
  - 0x02 WRITE: count byte N, then N data bytes (N=0 means 256). Each data byte emits oMemWr at ptr; ptr <= ptr+1 after each byte.
  - 0x03 IO_WRITE: port lo, port hi, data. Emits one oIoWr with oAddr={4'h0, hi, lo}. ptr unchanged.
  - Any other byte in IDLE: oErr pulse, stay IDLE.
- States: IDLE, ADDR0, ADDR1, ADDR2, COUNT, DATA, IO0, IO1, IO2. Every state advances only on iValid.
  - IDLE: 0x01->ADDR0, 0x02->COUNT, 0x03->IO0.
  - ADDR0->ADDR1->ADDR2->IDLE.
  - COUNT->DATA.
  - DATA: decrement remaining count; go to IDLE after the last byte.
  - IO0->IO1->IO2->IDLE.
- SET_ADDR bytes are staged in a shadow register. ptr is committed only on the third byte, so a timed-out SET_ADDR leaves ptr unchanged.
- ptr wraps 20'hFFFFF -> 20'h00000 with no error.
- Timeout counter:
  - Cleared on every iValid and while in IDLE; counts otherwise.
  - Reaching TIMEOUT_CYCLES forces IDLE, pulses oErr, and discards the partial packet.
  - Writes already emitted by a partial WRITE stand.
- iValid and timeout expiry in the same cycle: the byte wins; it is processed and the counter clears.

## Timing

- Reset values:
  - oAddr = ADDR_RESET, oData = 0.
  - oMemWr = oIoWr = oErr = oBusy = 0.
  - state IDLE, ptr = ADDR_RESET, timer 0.
- All outputs registered. A write strobe, its oAddr and its oData are asserted together in the cycle after the iValid of the completing byte (latency 1).
- oAddr/oData hold their last value between strobes.
- oBusy rises the cycle after a valid command byte. It falls the cycle after the final byte, coincident with the final strobe.
- Back-to-back iValid on consecutive cycles is supported: one byte per cycle, one strobe per cycle in DATA.
- Reset asserted mid-packet clears everything asynchronously. No strobe is emitted for that packet.
- oErr for a timeout fires the cycle after the counter reaches TIMEOUT_CYCLES.

## Structure

- Shared header uart_cmd_defs.vh holds:
  - command codes CMD_SET_ADDR=8'h01, CMD_WRITE=8'h02, CMD_IO_WRITE=8'h03;
  - the state encoding localparams, so the bench can probe state.
- Single module. The timeout counter is small enough to stay inline; no sub-module.
- Top-level integration:
  - The decoder sits directly after uartRx.
  - oMemWr/oAddr/oData drive the MDA write port.
  - oIoWr with oAddr 0x388/0x389 drives the OPL2 addr/data select.

## Test plan

- Reset, then WRITE 02 03 41 42 43: three oMemWr at B0000/B0001/B0002 with data 41/42/43; then ptr = B0003.
- 01 34 12 F5, then 02 01 AA: ptr = 51234 (upper nibble of F5 dropped); oMemWr addr 51234 data AA.
- 01 FF FF 0F, then 02 02 11 22: writes at FFFFF then 00000 (wrap).
- 03 88 03 20: single oIoWr, oAddr=00388, oData=20; no oMemWr; ptr unchanged.
- Timeout and unknown command (TIMEOUT_CYCLES reduced to 16 for the bench):
  - 01 34 12, then idle 16 cycles: oErr pulse, state IDLE, ptr unchanged.
  - Next 7F: oErr, no strobe.
  - Next 02 00 followed by 256 bytes: 256 consecutive oMemWr.
- Assert iReset in the middle of 02 04 .. after two data bytes: outputs return to reset values immediately. Trailing bytes 33 44 are treated as commands; each pulses oErr.

Source files
------------

// File: rtl/uart_cmd_decoder_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_decoder_pkg
// Shared definitions for the UART command decoder: command byte codes, the
// parser state encoding (visible to benches that want to probe state), and a
// helper that forms the 20-bit bus address used for IO writes.
// -----------------------------------------------------------------------------
package uart_cmd_decoder_pkg;

  // First byte of every packet selects the command.
  localparam logic [7:0] CMD_SET_ADDR = 8'h01;
  localparam logic [7:0] CMD_WRITE    = 8'h02;
  localparam logic [7:0] CMD_IO_WRITE = 8'h03;

  // Parser states; every state advances only when a byte arrives.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ADDR0 = 4'd1,
    ST_ADDR1 = 4'd2,
    ST_ADDR2 = 4'd3,
    ST_COUNT = 4'd4,
    ST_DATA  = 4'd5,
    ST_IO0   = 4'd6,
    ST_IO1   = 4'd7,
    ST_IO2   = 4'd8
  } state_e;

  // IO ports live in the low 16 bits of the shared address bus.
  function automatic logic [19:0] ioAddr(input logic [15:0] port);
    return {4'h0, port};
  endfunction

endpackage

// File: rtl/uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// uart_cmd_decoder
// Turns the valid-strobed byte stream from the UART receiver into single-cycle
// memory / IO write strobes. Packets:
//   01 a0 a1 a2      set memory pointer to {a2[3:0], a1, a0}
//   02 N d0..dN-1    write N bytes (N=0 means 256) at the pointer, post-increment
//   03 lo hi d       one IO write of d to port {hi, lo}
// Any other first byte pulses oErr. A mid-packet silence of TIMEOUT_CYCLES
// abandons the packet and pulses oErr so the parser resynchronises.
//
// Ports:
//   iClk    in   system clock
//   iReset  in   asynchronous active-high reset
//   iData   in   [7:0]  received byte
//   iValid  in   one-cycle strobe qualifying iData
//   oAddr   out  [19:0] write address (memory address, or {4'h0, port} for IO)
//   oData   out  [7:0]  write data
//   oMemWr  out  one-cycle memory write strobe
//   oIoWr   out  one-cycle IO write strobe
//   oBusy   out  high while a packet is in progress
//   oErr    out  one-cycle strobe on timeout or unknown command byte
// -----------------------------------------------------------------------------
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 250000,
  parameter logic [19:0] ADDR_RESET     = 20'hB0000
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic [7:0]  iData,
  input  logic        iValid,
  output logic [19:0] oAddr,
  output logic [7:0]  oData,
  output logic        oMemWr,
  output logic        oIoWr,
  output logic        oBusy,
  output logic        oErr
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT_CYCLES);

  state_e        state_q,  state_d;
  logic [19:0]   ptr_q,    ptr_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [7:0]    count_q,  count_d;
  logic [TW-1:0] timer_q,  timer_d;
  logic [19:0]   addr_q,   addr_d;
  logic [7:0]    data_q,   data_d;
  logic          memWr_q,  memWr_d;
  logic          ioWr_q,   ioWr_d;
  logic          err_q,    err_d;

  // State and output registers. Everything, including the write strobes,
  // is registered so consumers see clean one-cycle pulses.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= ADDR_RESET;
      shadow_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      addr_q   <= ADDR_RESET;
      data_q   <= '0;
      memWr_q  <= 1'b0;
      ioWr_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      memWr_q  <= memWr_d;
      ioWr_q   <= ioWr_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic. A byte always takes priority over timeout expiry in
  // the same cycle. SET_ADDR and IO_WRITE stage their address bytes in the
  // shadow register so an abandoned packet never disturbs the pointer.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    addr_d   = addr_q;
    data_d   = data_q;
    memWr_d  = 1'b0;
    ioWr_d   = 1'b0;
    err_d    = 1'b0;
    timer_d  = (iValid || state_q == ST_IDLE) ? '0 : timer_q + TW'(1);

    if (iValid) begin
      unique case (state_q)
        ST_IDLE: begin
          case (iData)
            CMD_SET_ADDR: state_d = ST_ADDR0;
            CMD_WRITE:    state_d = ST_COUNT;
            CMD_IO_WRITE: state_d = ST_IO0;
            default:      err_d   = 1'b1;
          endcase
        end
        ST_ADDR0: begin
          shadow_d[7:0] = iData;
          state_d       = ST_ADDR1;
        end
        ST_ADDR1: begin
          shadow_d[15:8] = iData;
          state_d        = ST_ADDR2;
        end
        ST_ADDR2: begin
          // Only the low nibble of the top byte fits the 20-bit space.
          ptr_d   = {iData[3:0], shadow_q};
          state_d = ST_IDLE;
        end
        ST_COUNT: begin
          // A count of 0 decrements to 255 on the first byte and reaches 1
          // on the 256th, giving the 256-byte block for free.
          count_d = iData;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          memWr_d = 1'b1;
          addr_d  = ptr_q;
          data_d  = iData;
          ptr_d   = ptr_q + 20'd1;
          count_d = count_q - 8'd1;
          if (count_q == 8'd1) begin
            state_d = ST_IDLE;
          end
        end
        ST_IO0: begin
          shadow_d[7:0] = iData;
          state_d       = ST_IO1;
        end
        ST_IO1: begin
          shadow_d[15:8] = iData;
          state_d        = ST_IO2;
        end
        ST_IO2: begin
          ioWr_d  = 1'b1;
          addr_d  = ioAddr(shadow_q);
          data_d  = iData;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && timer_q == TIMER_LIMIT) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      timer_d = '0;
    end
  end

  assign oAddr  = addr_q;
  assign oData  = data_q;
  assign oMemWr = memWr_q;
  assign oIoWr  = ioWr_q;
  assign oErr   = err_q;
  // Derived from the state register alone, so it behaves as a registered output.
  assign oBusy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_decoder
// Scoreboard bench for uart_cmd_decoder. Stimulus tasks keep a reference copy
// of the memory pointer and push the expected write strobes into a queue;
// a negedge monitor pops and compares each strobe the decoder produces and
// counts oErr pulses against the expected number.
// -----------------------------------------------------------------------------
module tb_uart_cmd_decoder;
  import uart_cmd_decoder_pkg::*;

  localparam int          TIMEOUT    = 16;
  localparam logic [19:0] ADDR_RESET = 20'hB0000;

  typedef struct packed {
    logic        isIo;
    logic [19:0] addr;
    logic [7:0]  data;
  } txn_t;

  logic        iClk;
  logic        iReset;
  logic [7:0]  iData;
  logic        iValid;
  logic [19:0] oAddr;
  logic [7:0]  oData;
  logic        oMemWr;
  logic        oIoWr;
  logic        oBusy;
  logic        oErr;

  txn_t        sbQueue[$];
  logic [19:0] tbPtr;
  int          expErr;
  int          errSeen;
  int          checksDone;
  int          checksPassed;

  uart_cmd_decoder #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .ADDR_RESET    (ADDR_RESET)
  ) dut (
    .iClk  (iClk),
    .iReset(iReset),
    .iData (iData),
    .iValid(iValid),
    .oAddr (oAddr),
    .oData (oData),
    .oMemWr(oMemWr),
    .oIoWr (oIoWr),
    .oBusy (oBusy),
    .oErr  (oErr)
  );

  // 100 MHz-style bench clock; only the cycle count matters here.
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Single comparison point; every check in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksDone++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    else
      checksPassed++;
  endtask

  // Drives one byte for exactly one cycle; call from a negedge. Consecutive
  // calls produce back-to-back valid cycles.
  task automatic applyStimulus(input logic [7:0] b);
    iData  = b;
    iValid = 1'b1;
    @(negedge iClk);
    iValid = 1'b0;
  endtask

  task automatic cmdSetAddr(input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] a2);
    applyStimulus(CMD_SET_ADDR);
    applyStimulus(a0);
    applyStimulus(a1);
    applyStimulus(a2);
    tbPtr = {a2[3:0], a1, a0};
  endtask

  // Block write of n bytes (1..256); data byte i is seed + i*step.
  task automatic cmdWrite(input int n, input logic [7:0] seed, input logic [7:0] step);
    logic [7:0] d;
    applyStimulus(CMD_WRITE);
    checkOutput("busyRise", oBusy, 1);
    applyStimulus(8'(n));
    for (int i = 0; i < n; i++) begin
      d = seed + 8'(i) * step;
      sbQueue.push_back('{isIo: 1'b0, addr: tbPtr, data: d});
      tbPtr = tbPtr + 20'd1;
      applyStimulus(d);
    end
    checkOutput("busyFall", oBusy, 0);
  endtask

  task automatic cmdIo(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] d);
    applyStimulus(CMD_IO_WRITE);
    applyStimulus(lo);
    applyStimulus(hi);
    sbQueue.push_back('{isIo: 1'b1, addr: {4'h0, hi, lo}, data: d});
    applyStimulus(d);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge iClk) begin
    txn_t exp;
    if (!iReset) begin
      if (oErr) errSeen++;
      if (oMemWr || oIoWr) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpectedStrobe", {30'd0, oIoWr, oMemWr}, 32'd0);
        end else begin
          exp = sbQueue.pop_front();
          checkOutput("strobeKind", {30'd0, oIoWr, oMemWr}, exp.isIo ? 32'd2 : 32'd1);
          checkOutput("strobeAddr", {12'd0, oAddr}, {12'd0, exp.addr});
          checkOutput("strobeData", {24'd0, oData}, {24'd0, exp.data});
        end
      end
    end
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checksDone   = 0;
    checksPassed = 0;
    expErr       = 0;
    errSeen      = 0;
    tbPtr        = ADDR_RESET;
    iReset       = 1'b1;
    iValid       = 1'b0;
    iData        = 8'h00;

    #1;
    checkOutput("rstAddr",  {12'd0, oAddr}, {12'd0, ADDR_RESET});
    checkOutput("rstData",  {24'd0, oData}, 32'd0);
    checkOutput("rstStrb",  {30'd0, oIoWr, oMemWr}, 32'd0);
    checkOutput("rstBusy",  oBusy, 0);
    checkOutput("rstErr",   oErr, 0);

    @(negedge iClk);
    @(negedge iClk);
    iReset = 1'b0;
    @(negedge iClk);

    // Basic block write from the reset pointer, then confirm post-increment.
    cmdWrite(3, 8'h41, 8'h01);
    cmdWrite(1, 8'h5A, 8'h00);

    // Set address drops a2[7:4].
    cmdSetAddr(8'h34, 8'h12, 8'hF5);
    cmdWrite(1, 8'hAA, 8'h00);

    // Pointer wrap at the top of the 20-bit space.
    cmdSetAddr(8'hFF, 8'hFF, 8'h0F);
    cmdWrite(2, 8'h11, 8'h11);

    // IO write leaves the pointer alone.
    cmdIo(8'h88, 8'h03, 8'h20);
    cmdWrite(1, 8'hC3, 8'h00);

    // Abandoned SET_ADDR: error exactly TIMEOUT+1 cycles after the last byte.
    applyStimulus(CMD_SET_ADDR);
    applyStimulus(8'h34);
    applyStimulus(8'h12);
    repeat (TIMEOUT) @(negedge iClk);
    checkOutput("preTimeoutErr",  oErr, 0);
    checkOutput("preTimeoutBusy", oBusy, 1);
    @(negedge iClk);
    expErr++;
    checkOutput("timeoutErr",  oErr, 1);
    checkOutput("timeoutBusy", oBusy, 0);
    cmdWrite(1, 8'hE7, 8'h00);

    // Unknown command byte.
    applyStimulus(8'h7F);
    expErr++;
    checkOutput("unknownErr",  oErr, 1);
    checkOutput("unknownBusy", oBusy, 0);

    // 256-byte block via count 0, fully back-to-back.
    cmdWrite(256, 8'h00, 8'h01);

    // Reset in the middle of a block write.
    applyStimulus(CMD_WRITE);
    applyStimulus(8'h04);
    sbQueue.push_back('{isIo: 1'b0, addr: tbPtr, data: 8'h55});
    tbPtr = tbPtr + 20'd1;
    applyStimulus(8'h55);
    sbQueue.push_back('{isIo: 1'b0, addr: tbPtr, data: 8'h66});
    applyStimulus(8'h66);
    #2 iReset = 1'b1;
    #1;
    checkOutput("midRstAddr", {12'd0, oAddr}, {12'd0, ADDR_RESET});
    checkOutput("midRstData", {24'd0, oData}, 32'd0);
    checkOutput("midRstBusy", oBusy, 0);
    checkOutput("midRstStrb", {29'd0, oErr, oIoWr, oMemWr}, 32'd0);
    @(negedge iClk);
    iReset = 1'b0;
    tbPtr  = ADDR_RESET;
    applyStimulus(8'h33);
    expErr++;
    applyStimulus(8'h44);
    expErr++;
    cmdWrite(1, 8'h77, 8'h00);

    repeat (4) @(negedge iClk);
    checkOutput("sbDrained", sbQueue.size(), 0);
    checkOutput("errCount",  errSeen, expErr);

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
